// File: rtl/data_ram_lat.sv
// Byte-lane data RAM with configurable latency and a req/ready/ack handshake.
// Optional address range checking with err_o is enabled by defining DATA_RAM_RANGE_CHK_EN.
module data_ram_lat #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DEPTH_LOG2 = 17,
   parameter int unsigned LAT        = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W/8-1:0] sel_i,
   input  logic [DATA_W-1:0]   data_i,
   output logic                ready_o,
   output logic                ack_o,
   output logic [DATA_W-1:0]   data_o
`ifdef DATA_RAM_RANGE_CHK_EN
   ,
   output logic                err_o
`endif
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned BL    = $clog2(NB);
   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

   state_t                state;
   logic [CNT_W-1:0]      count;
   logic                  we_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [NB-1:0]         sel_q;
   logic [DATA_W-1:0]     data_q;

   logic [7:0]            mem [NB][DEPTH];
   logic [DATA_W-1:0]     rd_word_c;
   logic                  last_c;
   logic                  oor_c;
   logic                  wr_commit_c;

   // Low byte-offset bits never select storage; upper bits only matter with range checking.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_i[BL-1:0], addr_i[ADDR_W-1:DEPTH_LOG2+BL]};

`ifdef DATA_RAM_RANGE_CHK_EN
   logic hi_q;

   always_ff @(posedge clk) begin
      if (state == IDLE && req_i && !rst) begin
         hi_q <= |addr_i[ADDR_W-1:DEPTH_LOG2+BL];
      end
   end

   assign oor_c = hi_q;
`else
   assign oor_c = 1'b0;
`endif

   assign ready_o     = (state == IDLE) && !rst;
   assign last_c      = (state == BUSY) && (count == '0);
   assign wr_commit_c = last_c && !rst && we_q && !oor_c;

   always_comb begin
      rd_word_c = '0;
      for (int k = 0; k < NB; k++) begin
         rd_word_c[8*k +: 8] = mem[k][idx_q];
      end
   end

   // Storage is never reset; only enabled lanes are written on the commit edge.
   always_ff @(posedge clk) begin
      if (wr_commit_c) begin
         for (int k = 0; k < NB; k++) begin
            if (sel_q[k]) begin
               mem[k][idx_q] <= data_q[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         ack_o  <= 1'b0;
         data_o <= '0;
`ifdef DATA_RAM_RANGE_CHK_EN
         err_o  <= 1'b0;
`endif
      end else begin
         ack_o <= 1'b0;
         case (state)
            IDLE: begin
               if (req_i) begin
                  we_q   <= we_i;
                  idx_q  <= addr_i[DEPTH_LOG2+BL-1:BL];
                  sel_q  <= sel_i;
                  data_q <= data_i;
                  count  <= CNT_W'(LAT - 1);
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (count == '0) begin
                  ack_o  <= 1'b1;
                  data_o <= (we_q || oor_c) ? '0 : rd_word_c;
`ifdef DATA_RAM_RANGE_CHK_EN
                  err_o  <= oor_c;
`endif
                  state  <= ACK;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_ram_lat.sv
// Directed bench for data_ram_lat: one LAT=1 and one LAT=3 instance, both with 1K words.
module tb_data_ram_lat;

   logic        clk = 1'b0;
   logic        rst;
   logic        req1, req3;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic        ready1, ready3, ack1, ack3;
   logic [31:0] data1, data3;
`ifdef DATA_RAM_RANGE_CHK_EN
   logic        err1, err3;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   data_ram_lat #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .LAT(1)) dut1 (
      .clk(clk), .rst(rst), .req_i(req1), .we_i(we), .addr_i(addr), .sel_i(sel),
      .data_i(wdata), .ready_o(ready1), .ack_o(ack1), .data_o(data1)
`ifdef DATA_RAM_RANGE_CHK_EN
      , .err_o(err1)
`endif
   );

   data_ram_lat #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req_i(req3), .we_i(we), .addr_i(addr), .sel_i(sel),
      .data_i(wdata), .ready_o(ready3), .ack_o(ack3), .data_o(data3)
`ifdef DATA_RAM_RANGE_CHK_EN
      , .err_o(err3)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete access on the chosen instance; returns at the negedge where ack is high.
   task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, output logic [31:0] rd, output logic got_ack,
                       output logic got_err);
      @(negedge clk);
      we = w; addr = a; sel = s; wdata = wd;
      if (d == 1) req1 = 1'b1; else req3 = 1'b1;
      @(posedge clk);
      #1;
      req1 = 1'b0; req3 = 1'b0;
      got_ack = 1'b0; got_err = 1'b0; rd = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((d == 1) ? ack1 : ack3) begin
            got_ack = 1'b1;
            rd = (d == 1) ? data1 : data3;
`ifdef DATA_RAM_RANGE_CHK_EN
            got_err = (d == 1) ? err1 : err3;
`endif
            break;
         end
      end
   endtask

   logic [31:0] rd;
   logic        ga, ge;
   int          hits;

   initial begin
      rst = 1'b1; req1 = 1'b0; req3 = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", 64'(ready1), 64'd0);
      check("rst_ack", 64'(ack1), 64'd0);
      check("rst_data", 64'(data3), 64'd0);
      rst = 1'b0;
      #1 check("rst_release_ready", 64'(ready3), 64'd1);

      // LAT=1 write with cycle-level handshake checks
      @(negedge clk);
      we = 1'b1; addr = 32'h10; sel = 4'hF; wdata = 32'hDEADBEEF; req1 = 1'b1;
      @(negedge clk);
      req1 = 1'b0;
      check("t1_busy_ready", 64'(ready1), 64'd0);
      check("t1_busy_ack", 64'(ack1), 64'd0);
      @(negedge clk);
      check("t1_ack", 64'(ack1), 64'd1);
      check("t1_ack_ready", 64'(ready1), 64'd0);
      check("t1_wr_data_zero", 64'(data1), 64'd0);
      @(negedge clk);
      check("t1_post_ack", 64'(ack1), 64'd0);
      check("t1_post_ready", 64'(ready1), 64'd1);
      xact(1, 1'b0, 32'h10, 4'hF, 32'h0, rd, ga, ge);
      check("t1_rd_ack", 64'(ga), 64'd1);
      check("t1_rd_data", 64'(rd), 64'hDEADBEEF);

      // Partial-lane write, read back through an aliased byte address
      xact(1, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, rd, ga, ge);
      check("t2_wr_ack", 64'(ga), 64'd1);
      xact(1, 1'b0, 32'h13, 4'hF, 32'h0, rd, ga, ge);
      check("t2_rd_data", 64'(rd), 64'hDEADAAEF);

      // LAT=3 read with a competing request held during busy
      xact(3, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, rd, ga, ge);
      check("t3_wr_ack", 64'(ga), 64'd1);
      @(negedge clk);
      we = 1'b0; addr = 32'h40; sel = 4'hF; req3 = 1'b1;
      @(negedge clk);
      addr = 32'h44;
      check("t3_e0_ready", 64'(ready3), 64'd0);
      check("t3_e0_ack", 64'(ack3), 64'd0);
      @(negedge clk);
      check("t3_e1_ack", 64'(ack3), 64'd0);
      check("t3_e1_ready", 64'(ready3), 64'd0);
      @(negedge clk);
      check("t3_e2_ack", 64'(ack3), 64'd0);
      @(negedge clk);
      req3 = 1'b0;
      check("t3_e3_ack", 64'(ack3), 64'd1);
      check("t3_e3_ready", 64'(ready3), 64'd0);
      check("t3_e3_data", 64'(data3), 64'hCAFEF00D);
      @(negedge clk);
      check("t3_e4_ready", 64'(ready3), 64'd1);
      check("t3_e4_ack", 64'(ack3), 64'd0);
      check("t3_e4_data_hold", 64'(data3), 64'hCAFEF00D);

      // LAT=3 write abandoned by reset one edge after accept
      xact(3, 1'b1, 32'h20, 4'hF, 32'h11112222, rd, ga, ge);
      check("t4_prior_ack", 64'(ga), 64'd1);
      @(negedge clk);
      we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'h12345678; req3 = 1'b1;
      @(negedge clk);
      req3 = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("t4_rst_ack", 64'(ack3), 64'd0);
      check("t4_rst_ready", 64'(ready3), 64'd0);
      rst = 1'b0;
      #1 check("t4_ready_after_rst", 64'(ready3), 64'd1);
      hits = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (ack3) hits++;
      end
      check("t4_no_ack", 64'(hits), 64'd0);
      xact(3, 1'b0, 32'h20, 4'hF, 32'h0, rd, ga, ge);
      check("t4_rd_ack", 64'(ga), 64'd1);
      check("t4_rd_prior", 64'(rd), 64'h11112222);

      // sel=0 write acks but stores nothing
      xact(1, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, rd, ga, ge);
      check("t5_ack", 64'(ga), 64'd1);
      check("t5_data_zero", 64'(rd), 64'd0);
      xact(1, 1'b0, 32'h10, 4'hF, 32'h0, rd, ga, ge);
      check("t5_unchanged", 64'(rd), 64'hDEADAAEF);

      // Out-of-range address for a 1K-word array
      xact(1, 1'b1, 32'h0, 4'hF, 32'h0BADC0DE, rd, ga, ge);
      check("t6_wr0_ack", 64'(ga), 64'd1);
      xact(1, 1'b0, 32'h01000000, 4'hF, 32'h0, rd, ga, ge);
      check("t6_oor_ack", 64'(ga), 64'd1);
`ifdef DATA_RAM_RANGE_CHK_EN
      check("t6_oor_err", 64'(ge), 64'd1);
      check("t6_oor_data", 64'(rd), 64'd0);
      xact(1, 1'b1, 32'h01000000, 4'hF, 32'h55555555, rd, ga, ge);
      check("t6_oor_wr_err", 64'(ge), 64'd1);
      xact(1, 1'b0, 32'h0, 4'hF, 32'h0, rd, ga, ge);
      check("t6_err_clear", 64'(ge), 64'd0);
      check("t6_wr_suppressed", 64'(rd), 64'h0BADC0DE);
`else
      check("t6_alias_data", 64'(rd), 64'h0BADC0DE);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
